lc3_mem_port: RTL and testbench
===============================

Name: lc3_mem_port

Overview:
- Parametrised LC-3 memory access unit: MAR, write-data latch, internal synchronous RAM, read-data register and a REQ/DONE handshake.
- Sits between the datapath bus (Y) and main memory. The control FSM issues single-word reads/writes and waits on DONE instead of assuming fixed timing.
- Adds configurable width/depth, multi-cycle read latency, busy/stall reporting and optional LC-3 display MMIO.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 16, MAR width.
- RAM_AW, 12, RAM index bits; depth = 2**RAM_AW; MAR[RAM_AW-1:0] indexes RAM, upper bits alias.
- READ_LATENCY, 1, cycles from read issue to data available; legal 1..4.

Ports:
- CLK  in  1  single clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- MAR_LE  in  1  load MAR when idle.
- MAR_CONTROL  in  1  MAR source: 1 = DATA (indirect), 0 = Y.
- Y  in  ADDR_W  address from datapath bus.
- RD_DATA  in  DATA_W  write data (register-file source operand).
- REQ  in  1  start access; sampled only in IDLE.
- WE  in  1  access type, sampled with REQ: 1 = write, 0 = read.
- BUSY  out  1  high whenever state != IDLE.
- DONE  out  1  one-cycle completion pulse.
- DATA  out  DATA_W  registered read data; held until the next read completes.
- DISP_DATA  out  8  (MMIO_EN only) last byte written to DDR.
- DISP_VALID  out  1  (MMIO_EN only) one-cycle pulse per DDR write.

Behaviour:
- Reset values: MAR=0, DATA=0, BUSY=0, DONE=0, state=IDLE, latency counter=0, DISP_DATA=0, DISP_VALID=0. RAM contents are not reset.
- MAR load: at a CLK edge with MAR_LE=1 and state=IDLE, MAR <= MAR_CONTROL ? DATA[ADDR_W-1:0] (zero-extended if DATA_W<ADDR_W) : Y. MAR_LE is ignored while BUSY.
- Access start: at an edge in IDLE with REQ=1, latch access address, WE and RD_DATA, then go to ACCESS.
  - If MAR_LE=1 at the same edge, the access uses the newly loaded MAR value, taken from the same mux as the MAR load.
- FSM states: IDLE, ACCESS, DONE.
- Write (WE=1): RAM is written at the first edge in ACCESS, then DONE. Latency: REQ sampled at edge 0, RAM written and DONE entered at edge 1.
- Read (WE=0): RAM address is presented in ACCESS and the counter runs READ_LATENCY cycles. DATA is loaded and DONE entered at edge READ_LATENCY+1 after REQ.
- DONE state: DONE=1 for exactly one cycle, then IDLE. REQ is ignored in ACCESS and DONE and is not queued.
- Minimum back-to-back period: write 3 cycles, read READ_LATENCY+3 cycles.
- DATA changes only on read completion. Writes leave DATA unchanged, and a write to the address just read does not update DATA.
- Address aliasing: MAR bits above RAM_AW are ignored by RAM, except the MMIO range when MMIO_EN is defined.
- RESET mid-operation: immediate return to IDLE with DONE=0.
  - A write not yet committed at the reset edge is dropped.
  - DATA is cleared to 0.
- REQ held high continuously: a new access starts on each return to IDLE.

Optional Feature:
- Macro: LC3_MEM_MMIO_EN.
- Defined:
  - Read of 16'hFE04 (DSR) returns 16'h8000 (display always ready) without touching RAM, with the same latency as a RAM read.
  - Write to 16'hFE06 (DDR) sets DISP_DATA <= RD_DATA[7:0] and pulses DISP_VALID with DONE; RAM is not written.
  - Both compare against the full ADDR_W MAR; requires ADDR_W=16.
- Undefined: no MMIO decode, DISP_* ports absent, all addresses alias into RAM.

Decomposition:
- Package lc3_mem_pkg: FSM state encoding (IDLE/ACCESS/DONE), MMIO addresses DSR_ADDR=16'hFE04 and DDR_ADDR=16'hFE06, DSR_READY=16'h8000.
- Sub-module lc3_sync_ram:
  - Parameters: DATA_W, RAM_AW, READ_LATENCY.
  - Single-port; write on wren at the clock edge; q valid READ_LATENCY cycles after address.
  - No reset on storage.

Test Plan:
- Reset, then MAR_LE=1, MAR_CONTROL=0, Y=16'h0123, REQ=1, WE=1, RD_DATA=16'hBEEF -> DONE pulses 1 cycle after the REQ edge, BUSY high for 2 cycles, DATA stays 0.
- Read of 16'h0123 with READ_LATENCY=1 and 3 -> DONE at edge 2 and edge 4 after REQ respectively; DATA=16'hBEEF held until the next read completes.
- Indirect: RAM[0x010]=16'h0123, RAM[0x123]=16'h5A5A. Read 0x010, then MAR_LE=1 with MAR_CONTROL=1, then read -> DATA=16'h5A5A.
- Aliasing: write 16'h1111 at 16'h1005, read 16'h0005 (RAM_AW=12) -> DATA=16'h1111. MAR_LE/REQ asserted while BUSY -> MAR unchanged, no extra DONE.
- RESET asserted in ACCESS of a write of 16'hFFFF to 16'h0020 (READ_LATENCY=1) -> BUSY/DONE drop immediately; subsequent read of 16'h0020 returns its prior value.
- With LC3_MEM_MMIO_EN: read 16'hFE04 -> DATA=16'h8000. Write 16'h0041 to 16'hFE06 -> DISP_DATA=8'h41 and DISP_VALID pulses with DONE; RAM[0xE06] unchanged.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// Shared definitions for the LC-3 memory port: FSM encoding and display MMIO addresses.
package lc3_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;
    localparam logic [15:0] DSR_READY = 16'h8000;

    // Wide enough to count READ_LATENCY up to 4.
    localparam int CNT_W = 3;

endpackage

// File: rtl/lc3_mem_port_if.sv
// Datapath-to-memory bus for lc3_mem_port; DISP_* signals exist only with LC3_MEM_MMIO_EN.
interface lc3_mem_port_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              MAR_LE;
    logic              MAR_CONTROL;
    logic [ADDR_W-1:0] Y;
    logic [DATA_W-1:0] RD_DATA;
    logic              REQ;
    logic              WE;
    logic              BUSY;
    logic              DONE;
    logic [DATA_W-1:0] DATA;
`ifdef LC3_MEM_MMIO_EN
    logic [7:0]        DISP_DATA;
    logic              DISP_VALID;
`endif

    modport master (
        output MAR_LE, MAR_CONTROL, Y, RD_DATA, REQ, WE,
`ifdef LC3_MEM_MMIO_EN
        input  DISP_DATA, DISP_VALID,
`endif
        input  BUSY, DONE, DATA
    );

    modport slave (
        input  MAR_LE, MAR_CONTROL, Y, RD_DATA, REQ, WE,
`ifdef LC3_MEM_MMIO_EN
        output DISP_DATA, DISP_VALID,
`endif
        output BUSY, DONE, DATA
    );
endinterface

// File: rtl/lc3_sync_ram.sv
// Single-port synchronous RAM with a READ_LATENCY-deep registered read path; storage is not reset.
module lc3_sync_ram #(
    parameter int DATA_W       = 16,
    parameter int RAM_AW       = 12,
    parameter int READ_LATENCY = 1
) (
    input  logic              i_clk,
    input  logic              i_wren,
    input  logic [RAM_AW-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_q
);
    logic [DATA_W-1:0] r_mem  [2**RAM_AW];
    logic [DATA_W-1:0] r_q_p  [READ_LATENCY];

    always_ff @(posedge i_clk) begin
        if (i_wren) r_mem[i_addr] <= i_wdata;
    end

    // Read pipeline: stage 0 samples the array, later stages only delay.
    always_ff @(posedge i_clk) begin
        r_q_p[0] <= r_mem[i_addr];
        for (int i = 1; i < READ_LATENCY; i++) r_q_p[i] <= r_q_p[i-1];
    end

    assign o_q = r_q_p[READ_LATENCY-1];
endmodule

// File: rtl/lc3_mem_port.sv
// LC-3 memory access unit: MAR, write latch, RAM, read-data register and REQ/DONE handshake.
// Define LC3_MEM_MMIO_EN to decode the display status (DSR) and data (DDR) registers.
module lc3_mem_port
    import lc3_mem_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 16,
    parameter int RAM_AW       = 12,
    parameter int READ_LATENCY = 1
) (
    input  logic          CLK,
    input  logic          RESET,
    lc3_mem_port_if.slave bus
);
    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_mar, w_mar_src, w_data_addr;
    logic [DATA_W-1:0] r_wdata, r_data, w_ram_q, w_rd_value;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    logic              w_start, w_write_commit, w_read_done, w_ram_we;
    logic              w_busy, w_done;
    logic              w_unused_mar;

    generate
        if (DATA_W >= ADDR_W) begin : g_data_trunc
            assign w_data_addr = r_data[ADDR_W-1:0];
        end else begin : g_data_zext
            assign w_data_addr = {{(ADDR_W-DATA_W){1'b0}}, r_data};
        end
    endgenerate

    assign w_mar_src      = bus.MAR_CONTROL ? w_data_addr : bus.Y;
    assign w_start        = (r_state == ST_IDLE) && bus.REQ;
    assign w_write_commit = (r_state == ST_ACCESS) && r_we;
    assign w_read_done    = (r_state == ST_ACCESS) && !r_we &&
                            (r_cnt == CNT_W'(READ_LATENCY));
    // Upper MAR bits only alias into RAM.
    assign w_unused_mar   = ^r_mar;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (bus.REQ) w_state_nxt = ST_ACCESS;
            ST_ACCESS: if (r_we || w_read_done) w_state_nxt = ST_DONE;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            ST_ACCESS: w_busy = 1'b1;
            ST_DONE: begin
                w_busy = 1'b1;
                w_done = 1'b1;
            end
            default: ;
        endcase
    end

    // The access address is r_mar itself: MAR cannot reload while busy.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_mar  <= '0;
            r_data <= '0;
            r_cnt  <= '0;
            r_we   <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && bus.MAR_LE) r_mar <= w_mar_src;
            if (w_start) begin
                r_we  <= bus.WE;
                r_cnt <= '0;
            end else if (r_state == ST_ACCESS && !r_we && !w_read_done) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_read_done) r_data <= w_rd_value;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_start) r_wdata <= bus.RD_DATA;
    end

`ifdef LC3_MEM_MMIO_EN
    logic       w_is_dsr, w_is_ddr;
    logic [7:0] r_disp_data;
    logic       r_disp_valid;

    assign w_is_dsr   = (r_mar == DSR_ADDR);
    assign w_is_ddr   = (r_mar == DDR_ADDR);
    assign w_rd_value = w_is_dsr ? DATA_W'(DSR_READY) : w_ram_q;
    assign w_ram_we   = w_write_commit && !w_is_ddr;

    // DISP_VALID rises on the commit edge so it lines up with DONE.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_disp_data  <= '0;
            r_disp_valid <= 1'b0;
        end else begin
            r_disp_valid <= w_write_commit && w_is_ddr;
            if (w_write_commit && w_is_ddr) r_disp_data <= r_wdata[7:0];
        end
    end

    assign bus.DISP_DATA  = r_disp_data;
    assign bus.DISP_VALID = r_disp_valid;
`else
    assign w_rd_value = w_ram_q;
    assign w_ram_we   = w_write_commit;
`endif

    lc3_sync_ram #(
        .DATA_W      (DATA_W),
        .RAM_AW      (RAM_AW),
        .READ_LATENCY(READ_LATENCY)
    ) u_ram (
        .i_clk  (CLK),
        .i_wren (w_ram_we),
        .i_addr (r_mar[RAM_AW-1:0]),
        .i_wdata(r_wdata),
        .o_q    (w_ram_q)
    );

    assign bus.BUSY = w_busy;
    assign bus.DONE = w_done;
    assign bus.DATA = r_data;
endmodule

// File: tb/tb_lc3_mem_port.sv
// Bench for lc3_mem_port: a word-addressed memory model drives randomized and directed accesses.
module tb_lc3_mem_port;
    localparam int DW  = 16;
    localparam int AW  = 16;
    localparam int RAW = 12;
    localparam int RL  = 1;
    localparam int RL3 = 3;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;
    int   checks = 0;
    int   errors = 0;

    lc3_mem_port_if #(.DATA_W(DW), .ADDR_W(AW)) bus  ();
    lc3_mem_port_if #(.DATA_W(DW), .ADDR_W(AW)) bus3 ();

    lc3_mem_port #(.DATA_W(DW), .ADDR_W(AW), .RAM_AW(RAW), .READ_LATENCY(RL)) dut (
        .CLK(CLK), .RESET(RESET), .bus(bus)
    );
    lc3_mem_port #(.DATA_W(DW), .ADDR_W(AW), .RAM_AW(RAW), .READ_LATENCY(RL3)) dut3 (
        .CLK(CLK), .RESET(RESET), .bus(bus3)
    );

    always #5 CLK = ~CLK;

    // Reference model: memory words keyed by RAM index, MAR and read register.
    logic [15:0] mdl_mem [int];
    logic [15:0] m_mar  = 16'h0;
    logic [15:0] m_data = 16'h0;
    bit          m_data_known = 1'b1;
`ifdef LC3_MEM_MMIO_EN
    logic [7:0]  m_disp = 8'h0;
`endif

    function automatic int ridx(input logic [15:0] a);
        return int'(a) % (1 << RAW);
    endfunction

    function automatic bit is_dsr(input logic [15:0] a);
`ifdef LC3_MEM_MMIO_EN
        return a == 16'hFE04;
`else
        return (a == 16'hFE04) && 1'b0;
`endif
    endfunction

    function automatic bit is_ddr(input logic [15:0] a);
`ifdef LC3_MEM_MMIO_EN
        return a == 16'hFE06;
`else
        return (a == 16'hFE06) && 1'b0;
`endif
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.MAR_LE = 1'b0;  bus.MAR_CONTROL = 1'b0; bus.Y = '0;
        bus.RD_DATA = '0;   bus.REQ = 1'b0;         bus.WE = 1'b0;
        bus3.MAR_LE = 1'b0; bus3.MAR_CONTROL = 1'b0; bus3.Y = '0;
        bus3.RD_DATA = '0;  bus3.REQ = 1'b0;         bus3.WE = 1'b0;
    endtask

    // One access on the main port, checked every cycle until it is back in IDLE.
    task automatic do_access(input bit mar_le, input bit mar_ctl, input logic [15:0] y,
                             input bit we, input logic [15:0] wd, input bit noise,
                             input string tag);
        logic [15:0] addr, old_data, new_data;
        bit          old_known, new_known, ddr_wr;
        int          dedge;
`ifdef LC3_MEM_MMIO_EN
        logic [7:0]  old_disp;
        old_disp = m_disp;
`endif
        bus.MAR_LE = mar_le; bus.MAR_CONTROL = mar_ctl; bus.Y = y;
        bus.REQ = 1'b1;      bus.WE = we;               bus.RD_DATA = wd;
        if (mar_le) m_mar = mar_ctl ? m_data : y;
        addr      = m_mar;
        old_data  = m_data;
        old_known = m_data_known;
        new_data  = m_data;
        new_known = m_data_known;
        ddr_wr    = 1'b0;
        if (we) begin
            dedge = 1;
            if (is_ddr(addr)) ddr_wr = 1'b1;
            else              mdl_mem[ridx(addr)] = wd;
`ifdef LC3_MEM_MMIO_EN
            if (ddr_wr) m_disp = wd[7:0];
`endif
        end else begin
            dedge = RL + 1;
            if (is_dsr(addr)) begin
                new_data = 16'h8000; new_known = 1'b1;
            end else if (mdl_mem.exists(ridx(addr))) begin
                new_data = mdl_mem[ridx(addr)]; new_known = 1'b1;
            end else begin
                new_known = 1'b0;
            end
        end
        for (int j = 0; j <= dedge + 1; j++) begin
            tick();
            checks++;
            if (bus.BUSY !== (j <= dedge)) begin
                errors++;
                $display("FAIL %s busy j=%0d: got %b expected %b", tag, j, bus.BUSY, (j <= dedge));
            end
            checks++;
            if (bus.DONE !== (j == dedge)) begin
                errors++;
                $display("FAIL %s done j=%0d: got %b expected %b", tag, j, bus.DONE, (j == dedge));
            end
            if ((j >= dedge) ? new_known : old_known) begin
                checks++;
                if (bus.DATA !== ((j >= dedge) ? new_data : old_data)) begin
                    errors++;
                    $display("FAIL %s data j=%0d: got %h expected %h", tag, j, bus.DATA,
                             (j >= dedge) ? new_data : old_data);
                end
            end
`ifdef LC3_MEM_MMIO_EN
            checks++;
            if (bus.DISP_VALID !== (ddr_wr && j == dedge)) begin
                errors++;
                $display("FAIL %s disp_valid j=%0d: got %b expected %b", tag, j, bus.DISP_VALID,
                         (ddr_wr && j == dedge));
            end
            checks++;
            if (bus.DISP_DATA !== ((j >= dedge) ? m_disp : old_disp)) begin
                errors++;
                $display("FAIL %s disp_data j=%0d: got %h expected %h", tag, j, bus.DISP_DATA,
                         (j >= dedge) ? m_disp : old_disp);
            end
`endif
            // While busy, MAR_LE and REQ must have no effect.
            if (noise && j <= dedge) begin
                bus.MAR_LE = 1'b1; bus.MAR_CONTROL = 1'($urandom); bus.Y = 16'($urandom);
                bus.REQ = 1'b1;    bus.WE = 1'($urandom);          bus.RD_DATA = 16'($urandom);
            end else begin
                bus.MAR_LE = 1'b0; bus.REQ = 1'b0;
            end
        end
        m_data       = new_data;
        m_data_known = new_known;
    endtask

    task automatic test_reset();
        idle_inputs();
        RESET = 1'b1;
        repeat (2) tick();
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", bus.BUSY); end
        checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", bus.DONE); end
        checks++; if (bus.DATA !== 16'h0) begin errors++; $display("FAIL rst_data: got %h expected 0000", bus.DATA); end
        checks++; if (bus3.DATA !== 16'h0) begin errors++; $display("FAIL rst_data3: got %h expected 0000", bus3.DATA); end
`ifdef LC3_MEM_MMIO_EN
        checks++; if (bus.DISP_DATA !== 8'h0 || bus.DISP_VALID !== 1'b0) begin
            errors++; $display("FAIL rst_disp: got %h/%b expected 00/0", bus.DISP_DATA, bus.DISP_VALID);
        end
`endif
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_write_basic();
        do_access(1'b1, 1'b0, 16'h0123, 1'b1, 16'hBEEF, 1'b0, "wr_basic");
    endtask

    task automatic test_read_latency();
        do_access(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, "rd_basic");
        do_access(1'b1, 1'b0, 16'h0777, 1'b1, 16'h2222, 1'b0, "wr_other");
        checks++;
        if (bus.DATA !== 16'hBEEF) begin errors++; $display("FAIL rd_hold: got %h expected BEEF", bus.DATA); end
    endtask

    task automatic test_indirect();
        do_access(1'b1, 1'b0, 16'h0010, 1'b1, 16'h0123, 1'b0, "ind_wr_ptr");
        do_access(1'b1, 1'b0, 16'h0123, 1'b1, 16'h5A5A, 1'b0, "ind_wr_val");
        do_access(1'b1, 1'b0, 16'h0010, 1'b0, 16'h0,    1'b0, "ind_rd_ptr");
        bus.MAR_LE = 1'b1; bus.MAR_CONTROL = 1'b1; bus.Y = 16'hFFFF;
        m_mar = m_data;
        tick();
        bus.MAR_LE = 1'b0; bus.MAR_CONTROL = 1'b0;
        checks++;
        if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL mar_load_busy: got %b expected 0", bus.BUSY); end
        do_access(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, "ind_rd_val");
        checks++;
        if (bus.DATA !== 16'h5A5A) begin errors++; $display("FAIL ind_final: got %h expected 5A5A", bus.DATA); end
    endtask

    task automatic test_alias();
        do_access(1'b1, 1'b0, 16'h1005, 1'b1, 16'h1111, 1'b0, "alias_wr");
        do_access(1'b1, 1'b0, 16'h0005, 1'b0, 16'h0,    1'b1, "alias_rd_noisy");
        checks++;
        if (bus.DATA !== 16'h1111) begin errors++; $display("FAIL alias_data: got %h expected 1111", bus.DATA); end
        do_access(1'b1, 1'b0, 16'h0123, 1'b1, 16'hBEEF, 1'b1, "busy_wr_noisy");
        // MAR must still hold 0x0123 despite MAR_LE during the busy cycles.
        do_access(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, "mar_unchanged");
    endtask

    task automatic test_back_to_back();
        bit          we;
        int          p;
        logic [15:0] old;
        for (int pass = 0; pass < 2; pass++) begin
            we  = (pass == 0);
            p   = we ? 3 : RL + 3;
            old = m_data;
            bus.MAR_LE = 1'b1; bus.MAR_CONTROL = 1'b0; bus.Y = 16'h0345;
            bus.REQ = 1'b1;    bus.WE = we;            bus.RD_DATA = 16'hC0DE;
            m_mar = 16'h0345;
            if (we) mdl_mem[ridx(16'h0345)] = 16'hC0DE;
            for (int j = 0; j < 2 * p; j++) begin
                tick();
                bus.MAR_LE = 1'b0;
                if (j == 2 * p - 1) bus.REQ = 1'b0;
                checks++;
                if (bus.BUSY !== ((j % p) != p - 1)) begin
                    errors++; $display("FAIL b2b busy we=%0b j=%0d: got %b", we, j, bus.BUSY);
                end
                checks++;
                if (bus.DONE !== ((j % p) == p - 2)) begin
                    errors++; $display("FAIL b2b done we=%0b j=%0d: got %b", we, j, bus.DONE);
                end
                if (!we || m_data_known) begin
                    checks++;
                    if (bus.DATA !== ((!we && j >= p - 2) ? 16'hC0DE : old)) begin
                        errors++; $display("FAIL b2b data we=%0b j=%0d: got %h", we, j, bus.DATA);
                    end
                end
            end
            if (!we) begin m_data = 16'hC0DE; m_data_known = 1'b1; end
        end
    endtask

    task automatic test_reset_mid();
        do_access(1'b1, 1'b0, 16'h0020, 1'b1, 16'h1234, 1'b0, "pre_wr");
        do_access(1'b0, 1'b0, 16'h0,    1'b0, 16'h0,    1'b0, "pre_rd");
        bus.MAR_LE = 1'b1; bus.Y = 16'h0020; bus.REQ = 1'b1; bus.WE = 1'b1; bus.RD_DATA = 16'hFFFF;
        tick();
        bus.MAR_LE = 1'b0; bus.REQ = 1'b0;
        checks++;
        if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL rstmid_pre_busy: got %b expected 1", bus.BUSY); end
        #1 RESET = 1'b1;
        #1;
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", bus.BUSY); end
        checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b expected 0", bus.DONE); end
        checks++; if (bus.DATA !== 16'h0) begin errors++; $display("FAIL rstmid_data: got %h expected 0000", bus.DATA); end
        #2 RESET = 1'b0;
        m_mar = 16'h0; m_data = 16'h0; m_data_known = 1'b1;
`ifdef LC3_MEM_MMIO_EN
        m_disp = 8'h0;
`endif
        tick();
        checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL rstmid_nodone: got %b expected 0", bus.DONE); end
        do_access(1'b1, 1'b0, 16'h0020, 1'b0, 16'h0, 1'b0, "rd_after_rst");
        checks++;
        if (bus.DATA !== 16'h1234) begin errors++; $display("FAIL rstmid_kept: got %h expected 1234", bus.DATA); end
    endtask

    task automatic test_random();
        logic [15:0] pool [8];
        logic [15:0] a;
        bit          we;
        for (int i = 0; i < 8; i++) pool[i] = 16'($urandom);
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: begin
                    we = !mdl_mem.exists(ridx(m_mar)) || 1'($urandom);
                    do_access(1'b0, 1'b0, 16'h0, we, 16'($urandom), 1'($urandom), "rnd_same");
                end
                1: begin
                    if (m_data_known)
                        do_access(1'b1, 1'b1, 16'($urandom), 1'b1, 16'($urandom), 1'($urandom), "rnd_ind");
                end
                default: begin
                    a  = pool[$urandom_range(0, 7)];
                    we = !mdl_mem.exists(ridx(a)) || 1'($urandom);
                    do_access(1'b1, 1'b0, a, we, 16'($urandom), 1'($urandom), "rnd");
                end
            endcase
        end
    endtask

`ifdef LC3_MEM_MMIO_EN
    task automatic test_mmio();
        do_access(1'b1, 1'b0, 16'h0E06, 1'b1, 16'h7777, 1'b0, "mmio_ram_wr");
        do_access(1'b1, 1'b0, 16'hFE06, 1'b1, 16'h0041, 1'b0, "ddr_wr");
        checks++;
        if (bus.DISP_DATA !== 8'h41) begin errors++; $display("FAIL ddr_byte: got %h expected 41", bus.DISP_DATA); end
        do_access(1'b1, 1'b0, 16'hFE04, 1'b0, 16'h0, 1'b0, "dsr_rd");
        checks++;
        if (bus.DATA !== 16'h8000) begin errors++; $display("FAIL dsr_val: got %h expected 8000", bus.DATA); end
        do_access(1'b1, 1'b0, 16'h0E06, 1'b0, 16'h0, 1'b0, "mmio_ram_rd");
        checks++;
        if (bus.DATA !== 16'h7777) begin errors++; $display("FAIL ddr_no_ram: got %h expected 7777", bus.DATA); end
    endtask
`endif

    task automatic l3_access(input bit we, input logic [15:0] a, input logic [15:0] wd,
                             input logic [15:0] exp_q, input logic [15:0] old_q, input string tag);
        int dedge;
        dedge = we ? 1 : RL3 + 1;
        bus3.MAR_LE = 1'b1; bus3.MAR_CONTROL = 1'b0; bus3.Y = a;
        bus3.REQ = 1'b1;    bus3.WE = we;            bus3.RD_DATA = wd;
        for (int j = 0; j <= dedge + 1; j++) begin
            tick();
            bus3.MAR_LE = 1'b0; bus3.REQ = 1'b0;
            checks++;
            if (bus3.BUSY !== (j <= dedge)) begin
                errors++; $display("FAIL %s busy j=%0d: got %b", tag, j, bus3.BUSY);
            end
            checks++;
            if (bus3.DONE !== (j == dedge)) begin
                errors++; $display("FAIL %s done j=%0d: got %b", tag, j, bus3.DONE);
            end
            checks++;
            if (bus3.DATA !== ((!we && j >= dedge) ? exp_q : old_q)) begin
                errors++; $display("FAIL %s data j=%0d: got %h expected %h", tag, j, bus3.DATA,
                                   (!we && j >= dedge) ? exp_q : old_q);
            end
        end
    endtask

    task automatic test_latency3();
        l3_access(1'b1, 16'h0123, 16'hBEEF, 16'h0,    16'h0,    "l3_wr");
        l3_access(1'b0, 16'h0123, 16'h0,    16'hBEEF, 16'h0,    "l3_rd");
        l3_access(1'b1, 16'h0123, 16'h1357, 16'h0,    16'hBEEF, "l3_wr2");
        l3_access(1'b0, 16'h1123, 16'h0,    16'h1357, 16'hBEEF, "l3_rd_alias");
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_write_basic();
        test_read_latency();
        test_indirect();
        test_alias();
        test_back_to_back();
        test_reset_mid();
`ifdef LC3_MEM_MMIO_EN
        test_mmio();
`endif
        test_random();
        test_latency3();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
